// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - opcode and state encodings plus operand signedness helpers for seq_mul_unit
package seq_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // rs1 is signed for MULH and MULHSU. MUL only keeps the low word, which is
  // the same whether or not the operands are signed, so MUL treats them as unsigned.
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is signed only for MULH
  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// rtl/seq_mul_unit_if.sv - request/response bundle between a requester and seq_mul_unit
interface seq_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             flush_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [1:0]       mini_opcode_i;
  logic             ready_o;
  logic             busy_o;
  logic [WIDTH-1:0] mul_out_o;
  logic             valid_o;

  modport master (
    output start_i, flush_i, a_i, b_i, mini_opcode_i,
    input  ready_o, busy_o, mul_out_o, valid_o
  );

  modport slave (
    input  start_i, flush_i, a_i, b_i, mini_opcode_i,
    output ready_o, busy_o, mul_out_o, valid_o
  );
endinterface

// File: rtl/seq_mul_unit_mul_digit_pp.sv
// rtl/seq_mul_unit_mul_digit_pp.sv - combinational |a| x one RADIX_BITS-wide digit partial product
module mul_digit_pp #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic [WIDTH-1:0]            a_mag_i,
  input  logic [RADIX_BITS-1:0]       digit_i,
  output logic [WIDTH+RADIX_BITS-1:0] pp_o
);

  // Both factors are widened to the product width, so the product cannot overflow
  assign pp_o = (WIDTH+RADIX_BITS)'(a_mag_i) * (WIDTH+RADIX_BITS)'(digit_i);

endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - handshaked radix-2^RADIX_BITS sequential RV32M multiplier (optional SEQ_MUL_EARLY_OUT_EN)
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int CTR_WIDTH  = 7
) (
  input  logic           clk_i,
  input  logic           reset_i,
  seq_mul_unit_if.slave  bus
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int AW = 2 * WIDTH;

  mul_state_e             state_q;
  logic [CTR_WIDTH-1:0]   ctr_q;
  logic [AW-1:0]          acc_q;
  logic [WIDTH-1:0]       a_mag_q;
  logic [WIDTH-1:0]       b_rem_q;   // |b| shifted right as digits are consumed
  logic                   neg_q;
  logic [1:0]             op_q;
  logic                   ready_q;
  logic                   valid_q;
  logic [WIDTH-1:0]       mul_out_q;

  // Operand magnitudes at accept time; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which fits unsigned
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op_a_signed(bus.mini_opcode_i) & bus.a_i[WIDTH-1];
  assign b_neg = op_b_signed(bus.mini_opcode_i) & bus.b_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag = b_neg ? -bus.b_i : bus.b_i;

  logic [WIDTH+RADIX_BITS-1:0] pp;
  mul_digit_pp #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp (
    .a_mag_i (a_mag_q),
    .digit_i (b_rem_q[RADIX_BITS-1:0]),
    .pp_o    (pp)
  );

  // Accumulate the shifted partial product, then form the signed product and the selected word
  logic [CTR_WIDTH+3:0] shamt;
  logic [AW-1:0]        acc_d;
  logic [AW-1:0]        prod;
  logic [WIDTH-1:0]     result;
  assign shamt  = (CTR_WIDTH+4)'(ctr_q) * (CTR_WIDTH+4)'(RADIX_BITS);
  assign acc_d  = acc_q + (AW'(pp) << shamt);
  assign prod   = neg_q ? -acc_d : acc_d;
  assign result = (op_q == MUL_OP_MUL) ? prod[WIDTH-1:0] : prod[AW-1:WIDTH];

  // The digit consumed this cycle is the final one
  logic run_last;
`ifdef SEQ_MUL_EARLY_OUT_EN
  logic [WIDTH-1:0] b_rest;
  assign b_rest   = b_rem_q >> RADIX_BITS;
  assign run_last = (ctr_q == CTR_WIDTH'(N-1)) || (b_rest == '0);
`else
  assign run_last = (ctr_q == CTR_WIDTH'(N-1));
`endif

  // Control FSM with registered handshake outputs. The result is registered on the
  // last RUN edge, so the DONE cycle is exactly the cycle that shows valid_o.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      ctr_q     <= '0;
      acc_q     <= '0;
      a_mag_q   <= '0;
      b_rem_q   <= '0;
      neg_q     <= 1'b0;
      op_q      <= MUL_OP_MUL;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      mul_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            a_mag_q <= a_mag;
            b_rem_q <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            op_q    <= bus.mini_opcode_i;
            acc_q   <= '0;
            ctr_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.flush_i) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            acc_q   <= acc_d;
            b_rem_q <= b_rem_q >> RADIX_BITS;
            ctr_q   <= ctr_q + CTR_WIDTH'(1);
            if (run_last) begin
              mul_out_q <= result;
              valid_q   <= 1'b1;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.busy_o    = !ready_q;
  assign bus.valid_o   = valid_q;
  assign bus.mul_out_o = mul_out_q;

endmodule
